// File: rtl/conv_window_feeder.sv
// conv_window_feeder: turns a raster pixel stream into 3x3 windows for
// convolution_core, runs the start/done handshake with the core and hands
// each core result to a valid/ready output stream.
module conv_window_feeder #(
    parameter int PIX_W      = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    output logic             pix_ready,
    output logic [31:0]      value0,
    output logic [31:0]      value1,
    output logic [31:0]      value2,
    output logic [31:0]      value3,
    output logic [31:0]      value4,
    output logic [31:0]      value5,
    output logic [31:0]      value6,
    output logic [31:0]      value7,
    output logic [31:0]      value8,
    output logic             caculating_start,
    input  logic             caculating_done,
    input  logic [31:0]      ret,
    output logic             res_done,
    output logic             res_valid,
    output logic [31:0]      res_data,
    input  logic             res_ready,
    output logic             frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        OUT,
        WAIT
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  col_q, col_d;
    logic [RW-1:0]  row_q, row_d;
    logic           pix_ready_q;
    logic           start_q;
    logic           res_valid_q;
    logic           res_done_q;
    logic           frame_done_q;
    logic [31:0]    res_data_q;

    // win_q[row][col]: row 0 is the oldest line, col 2 the newest column
    logic [2:0][2:0][PIX_W-1:0] win_q;

    // Line buffers: lb0 holds the previous row, lb1 the row before that
    logic [PIX_W-1:0] lb0_q [IMG_WIDTH];
    logic [PIX_W-1:0] lb1_q [IMG_WIDTH];

    logic accept;
    logic last_col;
    logic last_row;
    logic win_ok;
    logic frame_end;
    logic res_take;

    // pix_ready is only ever high in IDLE, so accept implies IDLE
    assign accept    = pix_valid & pix_ready_q;
    assign last_col  = (col_q == CW'(IMG_WIDTH - 1));
    assign last_row  = (row_q == RW'(IMG_HEIGHT - 1));
    assign win_ok    = (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign frame_end = accept & last_col & last_row;
    assign res_take  = (state_q == OUT) & res_valid_q & res_ready;

    // Raster position counters, advanced only on accepted pixels
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Next-state logic for the pixel / core / result handshake sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && win_ok)             state_d = CALC;
            CALC: if (caculating_done)              state_d = OUT;
            OUT:  if (res_valid_q && res_ready)     state_d = WAIT;
            WAIT: if (!caculating_done)             state_d = IDLE;
            default:                                state_d = IDLE;
        endcase
    end

    // State, counters, registered handshake outputs and result capture
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            pix_ready_q  <= 1'b0;
            start_q      <= 1'b0;
            res_valid_q  <= 1'b0;
            res_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
            res_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            // Outputs follow the state being entered so they line up with it
            pix_ready_q  <= (state_d == IDLE);
            start_q      <= (state_d == CALC);
            res_done_q   <= res_take;
            frame_done_q <= frame_end;
            if (state_q == CALC && caculating_done) begin
                res_data_q  <= ret;
                res_valid_q <= 1'b1;
            end else if (res_take) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    // Window shift: frozen outside accepts, so it stays put while the core works
    always_ff @(posedge clk) begin
        if (!reset) begin
            win_q <= '0;
        end else if (accept) begin
            for (int i = 0; i < 3; i++) begin
                win_q[i][0] <= win_q[i][1];
                win_q[i][1] <= win_q[i][2];
            end
            win_q[0][2] <= lb1_q[col_q];
            win_q[1][2] <= lb0_q[col_q];
            win_q[2][2] <= pix_data;
        end
    end

    // Line-buffer RAM: written on accept, never cleared
    always_ff @(posedge clk) begin
        if (reset && accept) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= pix_data;
        end
    end

    assign pix_ready        = pix_ready_q;
    assign caculating_start = start_q;
    assign res_valid        = res_valid_q;
    assign res_done         = res_done_q;
    assign res_data         = res_data_q;
    assign frame_done       = frame_done_q;

    assign value0 = 32'(win_q[0][0]);
    assign value1 = 32'(win_q[0][1]);
    assign value2 = 32'(win_q[0][2]);
    assign value3 = 32'(win_q[1][0]);
    assign value4 = 32'(win_q[1][1]);
    assign value5 = 32'(win_q[1][2]);
    assign value6 = 32'(win_q[2][0]);
    assign value7 = 32'(win_q[2][1]);
    assign value8 = 32'(win_q[2][2]);

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: a frame-array reference model queues the
// expected windows/results, a monitor pops and compares them, and a small
// behavioural convolution_core (kernel 1..9) closes the handshake loop.
module tb_conv_window_feeder;

    localparam int W = 4;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_ready;
    logic [31:0] value0, value1, value2, value3, value4, value5, value6, value7, value8;
    logic        caculating_start;
    logic        caculating_done;
    logic [31:0] ret;
    logic        res_done;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ready;
    logic        frame_done;

    conv_window_feeder #(.PIX_W(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .reset(reset),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .value0(value0), .value1(value1), .value2(value2), .value3(value3), .value4(value4),
        .value5(value5), .value6(value6), .value7(value7), .value8(value8),
        .caculating_start(caculating_start), .caculating_done(caculating_done), .ret(ret),
        .res_done(res_done), .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    wire [8:0][31:0] vv = {value8, value7, value6, value5, value4, value3, value2, value1, value0};

    typedef struct {
        logic [31:0]       ret;
        int                acc;
        logic [8:0][31:0]  w;
    } exp_t;

    exp_t        exp_q[$];
    int          fd_q[$];
    logic [31:0] got_q[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [7:0] img [H][W];
    int mr = 0, mc = 0;
    int rmode = 0;
    int hold = 0;
    int ccnt;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Behavioural convolution_core: done three cycles into start, cleared when start drops
    always @(posedge clk) begin
        if (!reset || !caculating_start) begin
            ccnt            <= 0;
            caculating_done <= 1'b0;
            ret             <= $urandom;
        end else if (ccnt == 2) begin
            caculating_done <= 1'b1;
            ret <= value0 * 1 + value1 * 2 + value2 * 3 + value3 * 4 + value4 * 5 +
                   value5 * 6 + value6 * 7 + value7 * 8 + value8 * 9;
        end else begin
            ccnt <= ccnt + 1;
            ret  <= $urandom;
        end
    end

    // Reference model: store the pixel in a frame array, queue a full window's result
    task automatic model_accept(input logic [7:0] d);
        exp_t e;
        img[mr][mc] = d;
        if (mr >= 2 && mc >= 2) begin
            e.ret = 0;
            for (int k = 0; k < 9; k++) begin
                e.w[k] = 32'(img[mr - 2 + k / 3][mc - 2 + k % 3]);
                e.ret  = e.ret + e.w[k] * (k + 1);
            end
            e.acc = cyc;
            exp_q.push_back(e);
        end
        if (mc == W - 1) begin
            mc = 0;
            if (mr == H - 1) begin
                mr = 0;
                fd_q.push_back(cyc + 1);
            end else begin
                mr++;
            end
        end else begin
            mc++;
        end
    endtask

    task automatic send_pix(input logic [7:0] d, input int gap);
        int n = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        forever begin
            @(negedge clk);
            if (pix_ready) break;
            n++;
            if (n > 200) begin
                fail_evt("pix_accept_timeout");
                break;
            end
        end
        if (n <= 200) model_accept(d);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_data  = 8'($urandom);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input bit rnd, input int gap);
        for (int p = 0; p < W * H; p++)
            send_pix(rnd ? 8'($urandom) : 8'(p + 1), gap < 0 ? int'($urandom_range(0, 2)) : gap);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || fd_q.size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (n >= 500) fail_evt("drain_timeout");
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Results of the 1..16 frame with kernel 1..9, worked out by hand
    task automatic check_seq(input int frames);
        logic [31:0] ref4 [4];
        ref4 = '{32'd348, 32'd393, 32'd528, 32'd573};
        chk("result_count", got_q.size(), 4 * frames);
        for (int i = 0; i < got_q.size() && i < 4 * frames; i++)
            chk($sformatf("result_seq[%0d]", i), got_q[i], ref4[i % 4]);
        got_q.delete();
    endtask

    // Downstream ready pattern
    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1: res_ready = ($urandom % 3) != 0;
                2: begin
                    if (res_valid && hold < 10) begin
                        res_ready = 1'b0;
                        hold++;
                    end else begin
                        res_ready = 1'b1;
                    end
                end
                default: res_ready = 1'b1;
            endcase
        end
    end

    // Monitor: compares windows, result latency/data/hold, res_done and frame_done
    initial begin
        logic        pv = 1'b0;
        logic        ps = 1'b0;
        logic        dexp = 1'b0;
        logic [31:0] held = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pv = 1'b0;
                ps = 1'b0;
                dexp = 1'b0;
                continue;
            end
            if (dexp || res_done) chk("res_done", res_done, dexp);
            dexp = 1'b0;
            if (frame_done) begin
                if (fd_q.size() == 0) fail_evt("frame_done_unexpected");
                else chk("frame_done_cycle", cyc, fd_q.pop_front());
            end
            if (caculating_start && !ps) begin
                if (exp_q.size() == 0) fail_evt("start_unexpected");
                else for (int k = 0; k < 9; k++) chk($sformatf("value%0d", k), vv[k], exp_q[0].w[k]);
            end
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    fail_evt("res_valid_unexpected");
                end else begin
                    if (!pv) chk("res_latency", cyc - exp_q[0].acc, 5);
                    else     chk("res_hold", res_data, held);
                    if (!res_ready) begin
                        chk("bp_pix_ready", pix_ready, 0);
                        chk("bp_start", caculating_start, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("res_data", res_data, e.ret);
                        got_q.push_back(res_data);
                        dexp = 1'b1;
                    end
                end
                held = res_data;
            end
            pv = res_valid && !res_ready;
            ps = caculating_start;
        end
    end

    initial begin
        reset     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_start", caculating_start, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_done", res_done, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_value0", value0, 0);
        chk("rst_value8", value8, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Continuous single frame
        frame(1'b0, 0);
        drain();
        check_seq(1);

        // Result backpressure for 10 cycles
        hold = 0;
        rmode = 2;
        frame(1'b0, 0);
        drain();
        rmode = 0;
        check_seq(1);

        // Two back-to-back frames
        frame(1'b0, 0);
        frame(1'b0, 0);
        drain();
        check_seq(2);

        // pix_valid toggling every cycle
        frame(1'b0, 1);
        drain();
        check_seq(1);

        // Reset while the core is calculating
        for (int p = 1; p <= 11; p++) send_pix(8'(p), 0);
        @(negedge clk);
        chk("calc_before_reset", caculating_start, 1);
        reset = 1'b0;
        exp_q.delete();
        fd_q.delete();
        got_q.delete();
        mr = 0;
        mc = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_start", caculating_start, 0);
        chk("rst_mid_res_valid", res_valid, 0);
        @(posedge clk);
        #1;
        frame(1'b0, 0);
        drain();
        check_seq(1);

        // Random pixels, random gaps, random downstream ready
        rmode = 1;
        for (int f = 0; f < 6; f++) frame(1'b1, -1);
        drain();
        rmode = 0;
        chk("random_results", got_q.size(), 6 * (W - 2) * (H - 2));
        got_q.delete();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Upstream feeder for convolution_core.
- Accepts a raster-order pixel stream and keeps two line buffers plus a 3x3 window register set.
- For every full 3x3 window, drives value0..value8 and runs the caculating_start/caculating_done handshake with the core.
- Returns each core result on a valid/ready output stream.

Parameters:
- PIX_W, 8, pixel width in bits; zero-extended to 32 bits on value ports.
- IMG_WIDTH, 640, pixels per row (minimum 3).
- IMG_HEIGHT, 480, rows per frame (minimum 3).

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-low reset.
- pix_valid  in  1  input pixel valid.
- pix_data  in  PIX_W  input pixel, raster order.
- pix_ready  out  1  feeder accepts pix_data this cycle.
- value0..value8  out  32 each  window to core, row-major; value0 = (r-2,c-2), value8 = (r,c).
- caculating_start  out  1  request to core; held high until caculating_done.
- caculating_done  in  1  core result ready.
- ret  in  32  core result.
- res_done  out  1  one-cycle pulse when a result is consumed downstream.
- res_valid  out  1  result available.
- res_data  out  32  captured ret.
- res_ready  in  1  downstream accepts res_data.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Reset acts on clk rising edge while reset==0.
- Reset values:
  - pix_ready=0, caculating_start=0, res_valid=0, res_done=0, frame_done=0.
  - res_data=0, value0..8=0, row/col counters=0, state=IDLE.
  - Line-buffer RAM is not cleared.
- Counters: col 0..IMG_WIDTH-1, row 0..IMG_HEIGHT-1, advanced on each accepted pixel (pix_valid & pix_ready).
  - col wraps to 0 and increments row.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0 and frame_done pulses the next cycle.
- On accept at (row,col):
  - Window columns shift left: win[i][0]<=win[i][1], win[i][1]<=win[i][2].
  - New column: win[0][2]<=lb1[col], win[1][2]<=lb0[col], win[2][2]<=pix_data.
  - Line buffers: lb1[col]<=lb0[col], lb0[col]<=pix_data.
  - Window crosses row boundaries un-flushed; validity is decided only by the counters.
- Window valid iff the accepted pixel has row>=2 and col>=2. This gives (IMG_WIDTH-2)*(IMG_HEIGHT-2) results per frame.
- FSM states:
  - IDLE: pix_ready=1. Accept of a non-valid-window pixel stays in IDLE (1 pixel/cycle). Accept of a valid-window pixel goes to CALC; pix_ready drops the next cycle.
  - CALC: caculating_start=1, window registers frozen. When caculating_done==1 is sampled: res_data<=ret, res_valid<=1, caculating_start<=0, go to OUT.
  - OUT: start=0. When res_valid & res_ready: res_valid<=0, res_done pulses 1 cycle, go to WAIT.
  - WAIT: stay until caculating_done==0, then go to IDLE. This guarantees the core has returned to its initial status.
- Latency with convolution_core: pixel accepted at cycle T -> caculating_start high from T+1 -> caculating_done at T+4 -> res_valid at T+5.
- Minimum spacing between valid-window results is 7 cycles.
- pix_ready is 0 in CALC, OUT and WAIT; pix_data is ignored there.
- res_valid stays high and res_data stays stable until accepted. No result is dropped or overwritten.
- Simultaneous events:
  - frame wrap and valid window on the same accept: both handled; frame_done pulses and CALC proceeds.
  - res_ready high on the same cycle res_valid rises: consumption is counted from the next cycle only.
- Reset mid-operation: returns to IDLE immediately, start drops, any pending result is discarded, counters restart at frame origin.
- Arithmetic: no arithmetic on pixels beyond zero-extension. ret is passed through unmodified (32-bit, no saturation).

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=4, pixels 1..16 streamed continuously, res_ready=1, real convolution_core (kernel 1..9) -> exactly 4 results: 348, 393, 528, 573. frame_done pulses once.
- Same stream, check first window -> value0..8 = 1,2,3,5,6,7,9,10,11 while caculating_start=1. res_valid exactly 5 cycles after pixel 11 is accepted.
- Backpressure: hold res_ready=0 for 10 cycles after the first result -> res_valid held, res_data=348 stable, pix_ready=0, no new caculating_start. Release -> res_done pulses once, remaining results 393, 528, 573 follow.
- Two back-to-back frames 1..16 then 1..16 -> result sequence 348, 393, 528, 573 repeated. Two frame_done pulses.
- pix_valid toggled 1/0 every cycle -> same four results. Counters advance only on accept.
- reset=0 for one cycle while in CALC -> start=0, res_valid=0 next cycle. A fresh frame 1..16 then yields 348, 393, 528, 573.
